// File: rtl/avalon_st_pkg.sv
// Shared definitions for the Avalon-ST channel switcher: the switcher state
// encoding, the Avalon-ST error field width and a width helper.
package avalon_st_pkg;

    localparam int AVST_ERR_W = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_MUTE = 1'b1
    } sw_state_e;

    // Width of a field that encodes values 0..value-1, never narrower than 1 bit.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/select_debouncer.sv
// Brings the asynchronous channel request into the clock domain and accepts
// it only after it has held one in-range value for STABLE_CYCLES clocks.
module select_debouncer
    import avalon_st_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 1000,
    parameter int SEL_W         = clog2_min1(CHANNELS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [SEL_W-1:0] select_i,
    output logic [SEL_W-1:0] sel_o,
    output logic             accept_o
);

    localparam int CNT_W = clog2_min1(STABLE_CYCLES + 1);

    logic [SEL_W-1:0] sync1_q, sync2_q, cand_q, sel_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, run_len;
    logic             eligible;

    // Length of the current run of one synchronized value, and acceptance decision
    always_comb begin
        // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
        run_len  = CNT_W'(1);
        cnt_d    = '0;
        eligible = (sync2_q != sel_q) && (int'(sync2_q) < CHANNELS);
        if (sync2_q == cand_q) begin
            run_len = cnt_q + 1'b1;
        end
        accept_o = eligible && (int'(run_len) >= STABLE_CYCLES);
        if (eligible && !accept_o) begin
            cnt_d = run_len;
        end
    end

    // Two-flop synchronizer, run tracking and the accepted-select register
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: reset clears the synchronizer as well, so an interrupted debounce never resumes after reset.
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample pre-edge values, which is what makes the 2-stage synchronizer two stages deep.
            sync1_q <= select_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            if (accept_o) begin
                sel_q <= sync2_q;
            end
        end
    end

    assign sel_o = sel_q;

endmodule

// File: rtl/avalon_st_switcher_n.sv
// N-input Avalon-ST sample switcher: routes one debounced channel to the
// source with one clock of latency, muting the first beats after a switch,
// and latches per-channel error flags.
module avalon_st_switcher_n
    import avalon_st_pkg::*;
#(
    parameter int                DATA_W        = 12,
    parameter int                CHANNELS      = 4,
    parameter int                STABLE_CYCLES = 1000,
    parameter int                MUTE_BEATS    = 16,
    parameter logic [DATA_W-1:0] MUTE_VALUE    = 12'h800,
    localparam int               SEL_W         = clog2_min1(CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [SEL_W-1:0]               select,
    input  logic [CHANNELS*DATA_W-1:0]     sink_data,
    input  logic [CHANNELS-1:0]            sink_valid,
    input  logic [AVST_ERR_W*CHANNELS-1:0] sink_error,
    output logic [DATA_W-1:0]              source_data,
    output logic                           source_valid,
    output logic [AVST_ERR_W-1:0]          source_error,
    output logic [SEL_W-1:0]               active_sel,
    output logic                           muting,
    output logic [CHANNELS-1:0]            err_sticky,
    input  logic                           err_clear
);

    localparam int MC_W = clog2_min1(MUTE_BEATS + 1);

    logic                  accept;
    logic [SEL_W-1:0]      acc_sel;
    logic [DATA_W-1:0]     cur_data;
    logic                  cur_valid;
    logic [AVST_ERR_W-1:0] cur_error;
    logic [CHANNELS-1:0]   err_hit;

    sw_state_e             state_q;
    logic [MC_W-1:0]       mute_cnt_q;
    logic [DATA_W-1:0]     src_data_q;
    logic                  src_valid_q;
    logic [AVST_ERR_W-1:0] src_error_q;
    logic [CHANNELS-1:0]   err_sticky_q;

    select_debouncer #(
        .CHANNELS      (CHANNELS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .SEL_W         (SEL_W)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .select_i (select),
        .sel_o    (acc_sel),
        .accept_o (accept)
    );

    // Pick the routed channel's beat and flag every channel's errored beats
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        cur_error = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            err_hit[i] = sink_valid[i] && (sink_error[i*AVST_ERR_W +: AVST_ERR_W] != '0);
            if (acc_sel == SEL_W'(i)) begin
                cur_data  = sink_data[i*DATA_W +: DATA_W];
                cur_valid = sink_valid[i];
                cur_error = sink_error[i*AVST_ERR_W +: AVST_ERR_W];
            end
        end
    end

    // RUN/MUTE state machine; the mute count only advances on routed valid beats
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_RUN;
            mute_cnt_q <= '0;
        end else if (accept && (MUTE_BEATS > 0)) begin
            state_q    <= ST_MUTE;
            mute_cnt_q <= MC_W'(MUTE_BEATS);
        end else if ((state_q == ST_MUTE) && cur_valid) begin
            mute_cnt_q <= mute_cnt_q - 1'b1;
            if (mute_cnt_q == MC_W'(1)) begin
                state_q <= ST_RUN;
            end
        end
    end

    // Registered source port; data and error hold across non-valid cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_data_q  <= '0;
            src_valid_q <= 1'b0;
            src_error_q <= '0;
        end else begin
            src_valid_q <= cur_valid;
            if (cur_valid) begin
                src_data_q  <= (state_q == ST_MUTE) ? MUTE_VALUE : cur_data;
                src_error_q <= cur_error;
            end
        end
    end

    // Sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_sticky_q <= '0;
        end else begin
            err_sticky_q <= err_hit | (err_clear ? '0 : err_sticky_q);
        end
    end

    assign source_data  = src_data_q;
    assign source_valid = src_valid_q;
    assign source_error = src_error_q;
    assign active_sel   = acc_sel;
    assign muting       = (state_q == ST_MUTE);
    assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_avalon_st_switcher_n.sv
// Randomized and directed bench for avalon_st_switcher_n against a
// cycle-level behavioural model of the switching rules.
module tb_avalon_st_switcher_n;

    localparam int DW  = 12;
    localparam int CH  = 4;
    localparam int STB = 8;
    localparam int MB  = 4;
    localparam logic [DW-1:0] MV = 12'h800;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [1:0]    select;
    logic [CH*DW-1:0] sink_data;
    logic [CH-1:0] sink_valid;
    logic [2*CH-1:0] sink_error;
    logic          err_clear;
    logic [DW-1:0] source_data;
    logic          source_valid;
    logic [1:0]    source_error;
    logic [1:0]    active_sel;
    logic          muting;
    logic [CH-1:0] err_sticky;

    // Second build with a non-power-of-two channel count for the out-of-range case
    logic [1:0]    sel3;
    logic [3*DW-1:0] sink_data3;
    logic [2:0]    sink_valid3;
    logic [5:0]    sink_error3;
    logic [DW-1:0] source_data3;
    logic          source_valid3;
    logic [1:0]    source_error3;
    logic [1:0]    active_sel3;
    logic          muting3;
    logic [2:0]    err_sticky3;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int            hist[$];
    int            m_active;
    int            m_mute_left;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic [1:0]    m_err;
    logic [CH-1:0] m_sticky;

    always #5 clk = ~clk;

    avalon_st_switcher_n #(
        .DATA_W(DW), .CHANNELS(CH), .STABLE_CYCLES(STB), .MUTE_BEATS(MB), .MUTE_VALUE(MV)
    ) dut (
        .clk(clk), .reset_n(reset_n), .select(select), .sink_data(sink_data),
        .sink_valid(sink_valid), .sink_error(sink_error), .source_data(source_data),
        .source_valid(source_valid), .source_error(source_error), .active_sel(active_sel),
        .muting(muting), .err_sticky(err_sticky), .err_clear(err_clear)
    );

    avalon_st_switcher_n #(
        .DATA_W(DW), .CHANNELS(3), .STABLE_CYCLES(STB), .MUTE_BEATS(MB), .MUTE_VALUE(MV)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .select(sel3), .sink_data(sink_data3),
        .sink_valid(sink_valid3), .sink_error(sink_error3), .source_data(source_data3),
        .source_valid(source_valid3), .source_error(source_error3), .active_sel(active_sel3),
        .muting(muting3), .err_sticky(err_sticky3), .err_clear(1'b0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_active    = 0;
        m_mute_left = 0;
        m_data      = '0;
        m_valid     = 1'b0;
        m_err       = '0;
        m_sticky    = '0;
    endtask

    // Advance the model across one clock edge using the inputs present now.
    task automatic model_edge();
        int  n;
        int  cand;
        bit  acc;
        n    = hist.size();
        cand = (n >= 2) ? hist[n-2] : 0;
        acc  = 1'b1;
        // Synchronized request = select two edges back; it must have held for STB edges.
        for (int j = 0; j < STB; j++) begin
            int idx;
            int v;
            idx = n - 2 - j;
            v   = (idx >= 0) ? hist[idx] : 0;
            if (v != cand) acc = 1'b0;
        end
        if (cand == m_active || cand >= CH) acc = 1'b0;

        m_valid = sink_valid[m_active];
        if (m_valid) begin
            m_data = (m_mute_left > 0) ? MV : sink_data[m_active*DW +: DW];
            m_err  = sink_error[m_active*2 +: 2];
        end
        if (acc) begin
            m_active    = cand;
            m_mute_left = MB;
        end else if (m_mute_left > 0 && m_valid) begin
            m_mute_left--;
        end

        for (int i = 0; i < CH; i++) begin
            if (sink_valid[i] && sink_error[i*2 +: 2] != 2'b00) m_sticky[i] = 1'b1;
            else if (err_clear) m_sticky[i] = 1'b0;
        end

        hist.push_back(int'(select));
        if (hist.size() > 32) void'(hist.pop_front());
    endtask

    task automatic check_outputs();
        check("valid",  source_valid, m_valid);
        check("data",   source_data,  m_data);
        check("error",  source_error, m_err);
        check("active", active_sel,   m_active);
        check("muting", muting,       (m_mute_left > 0));
        check("sticky", err_sticky,   m_sticky);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_sinks(input int valid_pct, input int err_pct);
        for (int i = 0; i < CH; i++) begin
            sink_valid[i]          = ($urandom_range(99) < valid_pct);
            sink_data[i*DW +: DW]  = DW'($urandom());
            sink_error[i*2 +: 2]   = ($urandom_range(99) < err_pct) ? 2'($urandom_range(3)) : 2'b00;
        end
    endtask

    initial begin
        reset_n = 1'b0; select = '0; err_clear = 1'b0;
        sink_data = '0; sink_valid = '0; sink_error = '0;
        sel3 = '0; sink_data3 = '0; sink_valid3 = '0; sink_error3 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        check("rst_active3", active_sel3, 0);
        check("rst_valid3", source_valid3, 0);
        reset_n = 1'b1;

        // Channel 0 beats every fourth clock carrying 0x123
        for (int c = 0; c < 24; c++) begin
            rand_sinks(30, 0);
            sink_valid[0] = (c % 4 == 0);
            sink_data[0 +: DW] = 12'h123;
            step();
            if (c % 4 == 0) check("ch0_data", source_data, 12'h123);
        end

        // Switch 0 -> 2: accept on the tenth edge, four muted beats, then live data
        select = 2'd2;
        for (int c = 1; c <= 18; c++) begin
            rand_sinks(50, 0);
            sink_valid[2] = 1'b1;
            sink_data[2*DW +: DW] = 12'h200 + 12'(c);
            step();
            if (c == 9)  check("pre_accept", active_sel, 0);
            if (c == 10) begin
                check("accept_sel", active_sel, 2);
                check("accept_mute", muting, 1);
            end
            if (c == 14) begin
                check("last_muted", source_data, 12'h800);
                check("mute_end", muting, 0);
            end
            if (c == 15) check("first_live", source_data, 12'h20F);
        end

        // Request toggling faster than the stability window is never accepted
        for (int c = 0; c < 40; c++) begin
            select = ((c / 5) % 2 == 0) ? 2'd1 : 2'd0;
            rand_sinks(50, 0);
            step();
        end
        check("toggle_hold", active_sel, 2);
        check("toggle_nomute", muting, 0);

        // Switch to 1 with sparse beats, then re-switch to 3 while still muting
        select = 2'd1;
        for (int c = 0; c < 20 && m_active != 1; c++) begin
            rand_sinks(40, 0);
            sink_valid[1] = (c % 6 == 5);
            step();
        end
        select = 2'd3;
        for (int c = 0; c < 20 && m_active != 3; c++) begin
            rand_sinks(40, 0);
            sink_valid[1] = (c % 5 == 4);
            step();
        end
        check("reswitch_sel", active_sel, 3);
        check("reswitch_mute", muting, 1);
        for (int c = 0; c < 12; c++) begin
            rand_sinks(40, 0);
            sink_valid[3] = (c % 2 == 0);
            step();
        end

        // Back to channel 0, then sticky error set / simultaneous clear
        select = 2'd0;
        for (int c = 0; c < 40 && (m_active != 0 || m_mute_left > 0); c++) begin
            rand_sinks(40, 0);
            sink_valid[0] = 1'b1;
            step();
        end
        sink_valid = 4'b0011; sink_error = 8'b0000_0100;
        step();
        check("sticky_set", err_sticky[1], 1);
        check("err_passthru", source_error, 0);
        err_clear = 1'b1;
        step();
        check("sticky_set_wins", err_sticky[1], 1);
        sink_error = '0;
        step();
        check("sticky_cleared", err_sticky, 0);
        err_clear = 1'b0;

        // Randomized traffic with occasional channel requests and clears
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(19) == 0) select = 2'($urandom_range(3));
            err_clear = ($urandom_range(19) == 0);
            rand_sinks(50, 10);
            step();
        end
        err_clear = 1'b0;

        // Reset in the middle of a mute: everything returns to channel 0 in RUN
        select = 2'(m_active + 1);
        for (int c = 0; c < 20 && m_mute_left == 0; c++) begin
            rand_sinks(0, 0);
            step();
        end
        check("pre_reset_mute", muting, 1);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        select  = 2'd0;
        for (int c = 0; c < 12; c++) begin
            rand_sinks(50, 0);
            step();
        end

        // Out-of-range request on the 3-channel build is ignored
        sel3 = 2'd3;
        for (int c = 0; c < 16; c++) begin
            step();
            check("oor_hold", active_sel3, 0);
        end
        check("oor_nomute", muting3, 0);
        sel3 = 2'd2;
        for (int c = 1; c <= 12; c++) begin
            step();
            check("ch3_accept", active_sel3, (c >= 10) ? 2 : 0);
        end
        check("ch3_mute", muting3, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/avalon_st_switcher_n.md
AVALON_ST_SWITCHER_N -- requirements
Module: avalon_st_switcher_n

Interface
REQ-001 Parameter DATA_W, default 12, sample width in bits.
REQ-002 Parameter CHANNELS, default 4, number of sink channels (2..16).
REQ-003 Parameter STABLE_CYCLES, default 1000, clocks a new select must hold before acceptance (>=1).
REQ-004 Parameter MUTE_BEATS, default 16, valid beats replaced by MUTE_VALUE after a switch; 0 disables muting.
REQ-005 Parameter MUTE_VALUE, default 12'h800, emitted sample during mute (midscale).
REQ-006 SEL_W is a derived local constant equal to max(1, clog2(CHANNELS)).
REQ-007 One clock and an asynchronous, active-low reset; the ports are clk and reset_n.
REQ-008 Port clk, input, 1, sole clock.
REQ-009 Port reset_n, input, 1, asynchronous active-low reset.
REQ-010 Port select, input, SEL_W, asynchronous channel request (switches).
REQ-011 Port sink_data, input, CHANNELS*DATA_W, channel i at bits [i*DATA_W +: DATA_W].
REQ-012 Port sink_valid, input, CHANNELS, per-channel Avalon-ST valid.
REQ-013 Port sink_error, input, 2*CHANNELS, channel i at bits [2i +: 2].
REQ-014 Port source_data, output, DATA_W, selected sample.
REQ-015 Port source_valid, output, 1, selected valid.
REQ-016 Port source_error, output, 2, selected error.
REQ-017 Port active_sel, output, SEL_W, currently routed channel.
REQ-018 Port muting, output, 1, high while in MUTE state.
REQ-019 Port err_sticky, output, CHANNELS, per-channel latched error flag.
REQ-020 Port err_clear, input, 1, synchronous clear of err_sticky.

Function
REQ-021 select SHALL pass through a 2-flop synchronizer before any use.
REQ-022 A synchronized select differing from active_sel SHALL be accepted only after being constant for STABLE_CYCLES consecutive clocks; any change restarts the count.
REQ-023 A synchronized select >= CHANNELS SHALL never be accepted; active_sel holds.
REQ-024 On acceptance, active_sel SHALL update on the same edge and state SHALL enter MUTE with mute counter = MUTE_BEATS (stay RUN if MUTE_BEATS=0).
REQ-025 States: RUN (pass-through) and MUTE; MUTE -> RUN on the edge where the counter decrements from 1 to 0.
REQ-026 In MUTE, the counter SHALL decrement only on cycles where sink_valid[active_sel] is high.
REQ-027 Acceptance during MUTE SHALL reload the counter and change active_sel, remaining in MUTE.
REQ-028 Output SHALL be registered, latency 1 clock: source_valid/error = sink_valid/error of active_sel one cycle earlier.
REQ-029 source_data SHALL be MUTE_VALUE for beats taken in MUTE, else sink data of active_sel; error passes unchanged in both states.
REQ-030 On a non-valid cycle, source_data and source_error SHALL hold their previous values.
REQ-031 The beat on the acceptance edge SHALL come from the old channel; the new channel's beats start the following cycle.
REQ-032 err_sticky[i] SHALL set when sink_valid[i] and sink_error[i] != 0, for every channel regardless of selection.
REQ-033 err_clear SHALL clear all err_sticky bits; a simultaneous set on the same edge wins for that bit.

Reset
REQ-034 While reset_n low: source_data 0, source_valid 0, source_error 0, active_sel 0, muting 0, err_sticky 0, state RUN, all counters and synchronizer flops 0.
REQ-035 Reset asserted mid-MUTE or mid-debounce SHALL abandon the operation; after release the block runs channel 0 in RUN, with no mute.

Structure
REQ-036 The state enumeration and the 2-bit Avalon-ST error width constant SHALL live in a shared package avalon_st_pkg.
REQ-037 Synchronizer plus stability counter SHALL be one sub-module select_debouncer (outputs accepted select and a one-cycle accept pulse).

Verification
REQ-038 Reset, select=0, ch0 valid every 4 clk with data 0x123 -> source_data 0x123, source_valid one clk after each sink valid.
REQ-039 select 0->2 held, STABLE_CYCLES=8, MUTE_BEATS=4 -> active_sel=2 exactly 2+8 clk after change, muting high, next 4 ch2 beats output 0x800, the 5th beat is ch2 data, muting low.
REQ-040 select toggles 1 and 0 every 5 clk with STABLE_CYCLES=8 -> active_sel never changes and muting stays 0.
REQ-041 select=3 during MUTE with 2 beats left -> counter reloads to 4, active_sel=3, 4 muted ch3 beats follow.
REQ-042 ch1 valid with error 2'b01 while ch0 active, err_clear pulsed on same edge as a second error -> err_sticky[1]=1 both times, source_error unaffected.
REQ-043 CHANNELS=4, select=3'b... out-of-range (CHANNELS=3 build, select=3) -> active_sel holds; reset_n pulsed low mid-MUTE -> all outputs 0, RUN, active_sel 0.
